// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO read arbiter: FSM state encoding, PIO
// address width and slave read latency, plus a pointer-width helper.
package pio_arb_pkg;

  localparam int unsigned PIO_ADDR_W     = 2;
  localparam int unsigned PIO_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_arb_prio_sel.sv
// Combinational winner selection.
// The search starts at index i_ptr and wraps through NREQ-1 back to 0; the
// first requesting index found is granted.
// Ports:
//   i_req   [NREQ-1:0]  request vector
//   i_ptr   [PTR_W-1:0] search start index (tie to 0 for fixed priority)
//   o_grant [NREQ-1:0]  one-hot grant, all zero when nothing requests
module pio_arb_prio_sel #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant
);

  int unsigned v_idx;
  logic        v_found;

  // Walk candidates in priority order; the inner loop keeps every bit
  // select on a constant index.
  always_comb begin
    o_grant = '0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = 32'(i_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!v_found && (i == v_idx) && i_req[i]) begin
          o_grant[i] = 1'b1;
          v_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one PIO read slave among NREQ requesters.
// A request is accepted in IDLE, the latched address is held on
// pio_address through WAIT and CAPTURE, and the slave's registered readdata
// is returned on rsp_data with a one-cycle rsp_valid strobe to the owner,
// three cycles after the accept.
// Build option: define PIO_ARB_ROUND_ROBIN_EN for round-robin arbitration
// with a rotating pointer; otherwise fixed priority, lowest index wins.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid[NREQ]       per-requester read request
//   req_address[2*NREQ]   per-requester address, requester i at [2i+1:2i]
//   req_ready[NREQ]       one-hot accept strobe (IDLE only)
//   rsp_valid[NREQ]       one-hot, one-cycle response strobe
//   rsp_data[DATA_W]      response data, held until the next capture
//   pio_address[2]        address to the PIO slave
//   pio_readdata[DATA_W]  slave readdata, registered one cycle after address
module pio_read_arbiter
  import pio_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [PIO_ADDR_W*NREQ-1:0] req_address,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [PIO_ADDR_W-1:0]      pio_address,
  input  logic [DATA_W-1:0]          pio_readdata
);

  localparam int unsigned PTR_W  = idx_width(NREQ);
  localparam int unsigned WCNT_W = idx_width(PIO_RD_LATENCY);

  state_t                  r_state;
  logic [NREQ-1:0]         r_owner;
  logic [NREQ-1:0]         r_rsp_valid;
  logic [DATA_W-1:0]       r_rsp_data;
  logic [PIO_ADDR_W-1:0]   r_pio_addr;
  logic [WCNT_W-1:0]       r_wait_cnt;

  logic [PTR_W-1:0]        w_ptr;
  logic [NREQ-1:0]         w_grant;
  logic [NREQ-1:0]         w_req_ready;
  logic                    w_accept;
  logic [PIO_ADDR_W-1:0]   w_sel_addr;

`ifdef PIO_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        w_grant_idx;

  // Binary index of the current winner, for the pointer update.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_grant_idx = PTR_W'(i);
    end
  end

  // Pointer moves to the slot just after the winner, wrapping at NREQ.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_grant_idx == PTR_W'(NREQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  pio_arb_prio_sel #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_prio_sel (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant)
  );

  // Ready is only offered while idle and out of reset.
  assign w_req_ready = (reset_n && (r_state == IDLE)) ? w_grant : '0;
  assign w_accept    = |w_req_ready;

  // Address of the winning requester, sampled only at accept.
  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_sel_addr = req_address[i*PIO_ADDR_W +: PIO_ADDR_W];
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_pio_addr  <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner    <= w_grant;
            r_pio_addr <= w_sel_addr;
            r_wait_cnt <= '0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          // Hold the address until the slave's registered data is ready.
          if (r_wait_cnt == WCNT_W'(PIO_RD_LATENCY - 1)) begin
            r_state <= CAPTURE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        CAPTURE: begin
          r_rsp_data  <= pio_readdata;
          r_rsp_valid <= r_owner;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign pio_address = r_pio_addr;

endmodule
